// File: rtl/qpsk_pkg.sv
// Shared types and constants for the QPSK transmit path.
package qpsk_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned GUARD_W = 8;
  localparam int unsigned AMP_W   = 16;

  // One-hot burst framing states.
  typedef enum logic [4:0] {
    ST_IDLE     = 5'b00001,
    ST_PREAMBLE = 5'b00010,
    ST_SYNC     = 5'b00100,
    ST_PAYLOAD  = 5'b01000,
    ST_GUARD    = 5'b10000
  } state_t;

  // Preamble 0x33 bytes map to an alternating symbol pattern.
  localparam logic [DATA_W-1:0] PREAMBLE_PATTERN_DEF = 32'h3333_3333;
  localparam logic [DATA_W-1:0] SYNC_WORD_DEF        = 32'h1ACF_FC1D;

  // Symbol amplitudes used by the bit-to-QPSK converter.
  localparam logic signed [AMP_W-1:0] AMP_ONE  = 16'sd23170;
  localparam logic signed [AMP_W-1:0] AMP_ZERO = -16'sd23170;

endpackage

// File: rtl/qpsk_burst_scheduler_if.sv
// Stream bundle around the scheduler: two payload sources in, one stream out.
interface qpsk_burst_scheduler_if;
  import qpsk_pkg::*;

  logic [DATA_W-1:0] s0_tdata;
  logic              s0_tvalid;
  logic              s0_tready;
  logic [DATA_W-1:0] s1_tdata;
  logic              s1_tvalid;
  logic              s1_tready;
  logic [DATA_W-1:0] m_tdata;
  logic              m_tvalid;
  logic              m_tready;

  // Scheduler side.
  modport master (
    input  s0_tdata, s0_tvalid, s1_tdata, s1_tvalid, m_tready,
    output s0_tready, s1_tready, m_tdata, m_tvalid
  );

  // Sources and converter side.
  modport slave (
    output s0_tdata, s0_tvalid, s1_tdata, s1_tvalid, m_tready,
    input  s0_tready, s1_tready, m_tdata, m_tvalid
  );
endinterface

// File: rtl/qpsk_burst_scheduler_rr_arbiter2.sv
// Two-request round-robin arbiter; grant is latched per burst.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       lock,
  input  logic       done,
  output logic       grant
);

  logic ptr_q;
  logic pick_c;

  // Pointer names the favoured source when both request.
  always_comb begin
    pick_c = grant;
    if (req == 2'b11) begin
      pick_c = ptr_q;
    end else if (req[1]) begin
      pick_c = 1'b1;
    end else if (req[0]) begin
      pick_c = 1'b0;
    end
  end

  // Grant loads at burst start; pointer moves off the winner at burst end.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant <= 1'b0;
      ptr_q <= 1'b0;
    end else begin
      if (lock) grant <= pick_c;
      if (done) ptr_q <= ~grant;
    end
  end

endmodule

// File: rtl/qpsk_burst_scheduler.sv
// Burst framer and two-source arbiter feeding the QPSK symbol converter.
module qpsk_burst_scheduler
  import qpsk_pkg::*;
#(
  parameter int unsigned       PREAMBLE_WORDS   = 4,
  parameter logic [DATA_W-1:0] PREAMBLE_PATTERN = PREAMBLE_PATTERN_DEF,
  parameter logic [DATA_W-1:0] SYNC_WORD        = SYNC_WORD_DEF,
  parameter int unsigned       BURST_WORDS      = 16,
  parameter int unsigned       GUARD_CYCLES     = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  qpsk_burst_scheduler_if.master  bus,
  output logic                    burst_active,
  output logic                    burst_src,
  output logic [CNT_W-1:0]        burst_count
);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    beat_q, beat_d;
  logic [GUARD_W-1:0]  guard_q, guard_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                grant;
  logic                lock;
  logic                done;
  logic                m_valid;
  logic [DATA_W-1:0]   m_data;
  logic                s0_rdy;
  logic                s1_rdy;

  rr_arbiter2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   ({bus.s1_tvalid, bus.s0_tvalid}),
    .lock  (lock),
    .done  (done),
    .grant (grant)
  );

  // State and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
      guard_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      guard_q <= guard_d;
      count_q <= count_d;
    end
  end

  // Next state, counters and stream muxing.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    guard_d = guard_q;
    count_d = count_q;
    lock    = 1'b0;
    done    = 1'b0;
    m_valid = 1'b0;
    m_data  = '0;
    s0_rdy  = 1'b0;
    s1_rdy  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.s0_tvalid || bus.s1_tvalid) begin
          lock    = 1'b1;
          state_d = ST_PREAMBLE;
          beat_d  = '0;
          guard_d = '0;
        end
      end
      ST_PREAMBLE: begin
        m_valid = 1'b1;
        m_data  = PREAMBLE_PATTERN;
        if (bus.m_tready) begin
          if (beat_q == CNT_W'(PREAMBLE_WORDS - 1)) begin
            state_d = ST_SYNC;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + CNT_W'(1);
          end
        end
      end
      ST_SYNC: begin
        m_valid = 1'b1;
        m_data  = SYNC_WORD;
        if (bus.m_tready) begin
          state_d = ST_PAYLOAD;
          beat_d  = '0;
        end
      end
      ST_PAYLOAD: begin
        m_valid = grant ? bus.s1_tvalid : bus.s0_tvalid;
        m_data  = grant ? bus.s1_tdata : bus.s0_tdata;
        s0_rdy  = !grant && bus.m_tready;
        s1_rdy  = grant && bus.m_tready;
        if (m_valid && bus.m_tready) begin
          if (beat_q == CNT_W'(BURST_WORDS - 1)) begin
            done    = 1'b1;
            count_d = count_q + CNT_W'(1);
            beat_d  = '0;
            guard_d = '0;
            state_d = (GUARD_CYCLES == 0) ? ST_IDLE : ST_GUARD;
          end else begin
            beat_d = beat_q + CNT_W'(1);
          end
        end
      end
      ST_GUARD: begin
        if (guard_q == GUARD_W'(GUARD_CYCLES - 1)) begin
          state_d = ST_IDLE;
          guard_d = '0;
        end else begin
          guard_d = guard_q + GUARD_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.m_tvalid  = m_valid;
  assign bus.m_tdata   = m_data;
  assign bus.s0_tready = s0_rdy;
  assign bus.s1_tready = s1_rdy;
  assign burst_active  = (state_q != ST_IDLE);
  assign burst_src     = grant;
  assign burst_count   = count_q;

endmodule

// File: doc/qpsk_burst_scheduler.md
# qpsk_burst_scheduler

Burst framing scheduler and two-source arbiter placed directly upstream of the 32-bit-to-QPSK-symbol converter. It grants one of two 32-bit AXI-Stream payload sources per burst using round-robin arbitration. Each burst is framed as preamble words, one sync word, a fixed-length payload from the granted source, and a guard gap. The converter therefore receives complete, well-separated bursts and never sees payload from two sources interleaved.

## Interface
- PREAMBLE_WORDS, 4: preamble beats per burst; legal range ≥1.
- PREAMBLE_PATTERN, 32'h3333_3333: preamble word; yields an alternating symbol pattern.
- SYNC_WORD, 32'h1ACF_FC1D: sync word, sent once per burst.
- BURST_WORDS, 16: payload beats per burst; legal range 1..65535.
- GUARD_CYCLES, 8: idle cycles after the payload; 0 skips GUARD; maximum 255.
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- s0_tdata  in  32  payload source 0 data.
- s0_tvalid  in  1  source 0 valid.
- s0_tready  out  1  source 0 ready.
- s1_tdata / s1_tvalid / s1_tready  in/in/out  32/1/1  payload source 1, same semantics as source 0.
- m_tdata  out  32  data to the converter.
- m_tvalid  out  1  valid to the converter.
- m_tready  in  1  ready from the converter.
- burst_active  out  1  high in every state except IDLE.
- burst_src  out  1  index of the granted source; holds its value after the burst ends.
- burst_count  out  16  number of completed bursts; wraps from 16'hFFFF to 0.

## Operation
- States: IDLE, PREAMBLE, SYNC, PAYLOAD, GUARD. The state is registered.
- m_tvalid, m_tdata and s*_tready are combinational from the registered state, grant and counters.
- IDLE:
  - If any s*_tvalid is high, latch the grant and go to PREAMBLE.
  - If both are high, grant the source that was not granted last. After reset, the round-robin pointer favours s0.
  - If only one is high, grant it.
  - m_tvalid=0 and both s*_tready=0.
- PREAMBLE:
  - m_tvalid=1, m_tdata=PREAMBLE_PATTERN.
  - beat_cnt increments on each m handshake.
  - After PREAMBLE_WORDS handshakes, clear beat_cnt and go to SYNC.
- SYNC:
  - m_tvalid=1, m_tdata=SYNC_WORD.
  - On handshake, go to PAYLOAD.
- PAYLOAD:
  - Pass-through of the granted source: m_tdata=sG_tdata, m_tvalid=sG_tvalid, sG_tready=m_tready.
  - The non-granted source's tready is 0.
  - beat_cnt counts handshakes. If the source stalls (tvalid low), the block waits; no padding is inserted.
  - On handshake number BURST_WORDS: burst_count increments, the round-robin pointer updates, and the state goes to GUARD (or to IDLE if GUARD_CYCLES=0).
- GUARD:
  - m_tvalid=0.
  - guard_cnt counts GUARD_CYCLES cycles, then the state goes to IDLE.
- Framing words hold m_tvalid and m_tdata stable until accepted. m_tvalid never deasserts without a handshake, provided the granted source obeys the same rule.
- A request that arrives while a burst is in progress waits. It is never dropped.
- Counter widths: beat_cnt is 16-bit and compares against BURST_WORDS and PREAMBLE_WORDS. guard_cnt is 8-bit. All counters clear on every state entry.

## Timing
- Reset values: m_tvalid=0, m_tdata=0, s0_tready=0, s1_tready=0, burst_active=0, burst_src=0, burst_count=0. State is IDLE and the pointer favours s0.
- Request to first preamble beat:
  - A request seen in IDLE in cycle N gives m_tvalid=1 in cycle N+1.
  - The requester's tdata is not consumed until PAYLOAD.
- Burst length with m_tready constantly high and sources never stalling: PREAMBLE_WORDS+1+BURST_WORDS cycles of m_tvalid, then GUARD_CYCLES idle cycles, then at least one IDLE cycle.
  - Burst-to-burst period at the defaults is 4+1+16+8+1 = 30 cycles.
- Payload path latency is 0 cycles (combinational pass-through).
- burst_count updates on the clock edge of the final payload handshake.
- Reset mid-burst:
  - All outputs return to their reset values immediately (asynchronous).
  - The partial burst is abandoned. The converter shares the same reset and discards its partial word.
- Simultaneous requests in the same IDLE cycle are resolved by the pointer only. Requests are never granted on a first-come basis across cycles.

## Structure
- Shared package qpsk_pkg holds:
  - state encoding constants (one-hot, 5 bits);
  - default PREAMBLE_PATTERN and SYNC_WORD;
  - the ONE/ZERO amplitude constants already used by the converter.
- Sub-module rr_arbiter2 implements two-request round-robin with a lock input. It contains the grant register and the pointer, and the pointer updates on burst completion. The FSM, counters and muxes stay in the top module.

## Test plan
- Single burst, defaults, m_tready=1, s0 streaming words 0x00000001..0x00000010 → m sees 4×0x33333333, then 0x1ACFFC1D, then 0x01..0x10; then 8 cycles with m_tvalid=0; burst_count=1; burst_src=0.
- Both sources requesting continuously → bursts alternate s0, s1, s0; payload never mixes sources; s1_tready=0 throughout every s0 burst.
- Backpressure: m_tready toggles 1-0-1-0 during PREAMBLE → m_tdata and m_tvalid stay stable while stalled; exactly 4 preamble handshakes occur.
- Source stall: s0_tvalid drops for 5 cycles after payload beat 7 → m_tvalid=0 for those 5 cycles; no extra beats; total payload handshakes = 16.
- GUARD_CYCLES=0, BURST_WORDS=1 → sequence is preamble×4, sync, one payload beat, then IDLE on the next cycle; burst_count increments each burst; wraps to 0 after 65536 bursts (verify by forcing the counter to 16'hFFFF).
- Reset asserted during payload beat 9 → all outputs are 0 in the same cycle; after release, the next burst starts with a full preamble and grants s0 first.
